// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencer for the iterative AES core.
// One accepted load request becomes a single key-load pulse, followed by
// NR round-advance enables, a final-round flag and a one-cycle done pulse.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active low
//   ld      in   start/restart request (highest priority)
//   stall   in   hold round progression while downstream is not ready
//   kld     out  key-load pulse to rcon / key expander
//   rnd     out  current round index 0..NR-1
//   rnd_en  out  advance round datapath this cycle (combinational from ld/stall)
//   last    out  current round is the final one (no MixColumns)
//   done    out  one-cycle result-valid pulse
//   busy    out  sequence in progress (INIT or RUN)
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic       stall,
  output logic       kld,
  output logic [3:0] rnd,
  output logic       rnd_en,
  output logic       last,
  output logic       done,
  output logic       busy
);

  localparam int unsigned RCNT_W   = 4;
  localparam logic [RCNT_W-1:0] LAST_RND = RCNT_W'(NR - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RCNT_W-1:0]   r_rcnt;
  logic [RCNT_W-1:0]   w_rcnt_nxt;
  logic                w_rnd_en;
  logic                r_kld;
  logic                r_last;
  logic                r_done;
  logic                r_busy;

  // State, round counter and decoded flags; flags are computed from the
  // next state so each output is a plain flop matching the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_kld   <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_kld   <= (w_state_nxt == INIT);
      r_last  <= (w_state_nxt == RUN) && (w_rcnt_nxt == LAST_RND);
      r_done  <= (w_state_nxt == DONE);
      r_busy  <= (w_state_nxt == INIT) || (w_state_nxt == RUN);
    end
  end

  // Next-state / counter logic; priority is ld > stall > progression.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rnd_en    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_rcnt_nxt = '0;
        if (ld) w_state_nxt = INIT;
      end
      INIT: begin
        w_rcnt_nxt  = '0;
        w_state_nxt = ld ? INIT : RUN;
      end
      RUN: begin
        if (ld) begin
          w_state_nxt = INIT;
          w_rcnt_nxt  = '0;
        end else if (!stall) begin
          w_rnd_en = 1'b1;
          // The final round exits to DONE instead of incrementing.
          if (r_rcnt == LAST_RND) w_state_nxt = DONE;
          else                    w_rcnt_nxt  = r_rcnt + RCNT_W'(1);
        end
      end
      DONE: begin
        w_rcnt_nxt  = '0;
        w_state_nxt = ld ? INIT : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  assign kld    = r_kld;
  assign rnd    = r_rcnt;
  assign rnd_en = w_rnd_en;
  assign last   = r_last;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: one NR=10 instance and one NR=14
// instance sharing the same stimulus.
module tb_aes_round_ctrl;

  logic       clk;
  logic       rst;
  logic       ld;
  logic       stall;

  logic       kld_a, rnd_en_a, last_a, done_a, busy_a;
  logic [3:0] rnd_a;
  logic       kld_b, rnd_en_b, last_b, done_b, busy_b;
  logic [3:0] rnd_b;

  int total;
  int bad;
  int n_en;

  aes_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .ld(ld), .stall(stall),
    .kld(kld_a), .rnd(rnd_a), .rnd_en(rnd_en_a),
    .last(last_a), .done(done_a), .busy(busy_a)
  );

  aes_round_ctrl #(.NR(14)) dut14 (
    .clk(clk), .rst(rst), .ld(ld), .stall(stall),
    .kld(kld_b), .rnd(rnd_b), .rnd_en(rnd_en_b),
    .last(last_b), .done(done_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare {kld,rnd,rnd_en,last,done,busy} of one instance (sel 0: NR=10, 1: NR=14).
  task automatic chk(input string tag, input bit sel, input logic k, input logic [3:0] r,
                     input logic e, input logic l, input logic d, input logic b);
    logic [8:0] obs;
    obs = sel ? {kld_b, rnd_b, rnd_en_b, last_b, done_b, busy_b}
              : {kld_a, rnd_a, rnd_en_a, last_a, done_a, busy_a};
    cmp(tag, 32'(obs), 32'({k, r, e, l, d, b}));
  endtask

  // Advance one cycle: inputs for the new cycle are set 2 units after the
  // edge and outputs are sampled 2 units later, well away from either edge.
  task automatic step(input logic ld_v, input logic stall_v);
    @(posedge clk);
    #2;
    ld    = ld_v;
    stall = stall_v;
    #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    ld    = 1'b0;
    stall = 1'b0;

    // Reset state
    #12;
    chk("reset10", 1'b0, 0, 4'd0, 0, 0, 0, 0);
    chk("reset14", 1'b1, 0, 4'd0, 0, 0, 0, 0);
    #10 rst = 1'b1;

    // Single run, NR=10, no stall
    step(1, 0);
    chk("s1_ldcyc", 0, 0, 4'd0, 0, 0, 0, 0);
    step(0, 0);
    chk("s1_init", 0, 1, 4'd0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      chk("s1_run", 0, 0, 4'(i), 1, (i == 9), 0, 1);
    end
    step(0, 0);
    chk("s1_done", 0, 0, 4'd9, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      chk("s1_idle", 0, 0, 4'd0, 0, 0, 0, 0);
    end

    // Restart every 6 cycles, 10 times: rnd peaks at 4, no done
    for (int k = 0; k < 10; k++) begin
      step(1, 0);
      if (k == 0) chk("s2_ld_idle", 0, 0, 4'd0, 0, 0, 0, 0);
      else        chk("s2_ld_run", 0, 0, 4'd4, 0, 0, 0, 1);
      step(0, 0);
      chk("s2_init", 0, 1, 4'd0, 0, 0, 0, 1);
      for (int j = 0; j < 4; j++) begin
        step(0, 0);
        chk("s2_run", 0, 0, 4'(j), 1, 0, 0, 1);
      end
    end
    for (int j = 4; j < 10; j++) begin
      step(0, 0);
      chk("s2_tail", 0, 0, 4'(j), 1, (j == 9), 0, 1);
    end
    step(0, 0);
    chk("s2_done", 0, 0, 4'd9, 0, 0, 1, 0);
    step(0, 0);
    chk("s2_idle", 0, 0, 4'd0, 0, 0, 0, 0);

    // Stall three cycles at rnd=4; done moves to t+15
    n_en = 0;
    step(1, 0);
    step(0, 0);
    chk("s3_init", 0, 1, 4'd0, 0, 0, 0, 1);
    for (int j = 0; j < 4; j++) begin
      step(0, 0);
      n_en += int'(rnd_en_a);
      chk("s3_pre", 0, 0, 4'(j), 1, 0, 0, 1);
    end
    for (int j = 0; j < 3; j++) begin
      step(0, 1);
      n_en += int'(rnd_en_a);
      chk("s3_stall", 0, 0, 4'd4, 0, 0, 0, 1);
    end
    for (int j = 4; j < 10; j++) begin
      step(0, 0);
      n_en += int'(rnd_en_a);
      chk("s3_post", 0, 0, 4'(j), 1, (j == 9), 0, 1);
    end
    step(0, 0);
    chk("s3_done", 0, 0, 4'd9, 0, 0, 1, 0);
    cmp("s3_en_count", 32'(n_en), 32'd10);
    step(0, 0);
    chk("s3_idle", 0, 0, 4'd0, 0, 0, 0, 0);

    // Stall on the final round holds last
    step(1, 0);
    step(0, 0);
    for (int j = 0; j < 9; j++) step(0, 0);
    step(0, 1);
    chk("s3b_last_stall", 0, 0, 4'd9, 0, 1, 0, 1);
    step(0, 0);
    chk("s3b_last_go", 0, 0, 4'd9, 1, 1, 0, 1);
    step(0, 0);
    chk("s3b_done", 0, 0, 4'd9, 0, 0, 1, 0);

    // Back-to-back: ld in every DONE cycle, 12-cycle period
    step(1, 0);
    chk("s4_ld0", 0, 0, 4'd0, 0, 0, 0, 0);
    for (int r = 0; r < 10; r++) begin
      step(0, 0);
      chk("s4_init", 0, 1, 4'd0, 0, 0, 0, 1);
      for (int j = 0; j < 10; j++) begin
        step(0, 0);
        chk("s4_run", 0, 0, 4'(j), 1, (j == 9), 0, 1);
      end
      step((r < 9) ? 1'b1 : 1'b0, 0);
      chk("s4_done", 0, 0, 4'd9, 0, 0, 1, 0);
    end
    step(0, 0);
    chk("s4_idle", 0, 0, 4'd0, 0, 0, 0, 0);

    // Rapid restart: ld / gap, 5 times; RUN is cut before any rnd_en
    for (int k = 0; k < 5; k++) begin
      step(1, 0);
      if (k == 0) chk("s5_ld_idle", 0, 0, 4'd0, 0, 0, 0, 0);
      else        chk("s5_ld_run", 0, 0, 4'd0, 0, 0, 0, 1);
      step(0, 0);
      chk("s5_init", 0, 1, 4'd0, 0, 0, 0, 1);
    end
    step(1, 0);
    chk("s5_final_ld", 0, 0, 4'd0, 0, 0, 0, 1);
    step(0, 0);
    chk("s5_final_init", 0, 1, 4'd0, 0, 0, 0, 1);
    for (int j = 0; j < 10; j++) begin
      step(0, 0);
      chk("s5_final_run", 0, 0, 4'(j), 1, (j == 9), 0, 1);
    end
    step(0, 0);
    chk("s5_final_done", 0, 0, 4'd9, 0, 0, 1, 0);
    for (int j = 0; j < 3; j++) begin
      step(0, 0);
      chk("s5_idle", 0, 0, 4'd0, 0, 0, 0, 0);
    end

    // Async reset while RUN at rnd=6
    step(1, 0);
    step(0, 0);
    for (int j = 0; j < 7; j++) begin
      step(0, 0);
      chk("s6_run", 0, 0, 4'(j), 1, 0, 0, 1);
    end
    #1 rst = 1'b0;
    #1;
    chk("s6_rst10", 0, 0, 4'd0, 0, 0, 0, 0);
    chk("s6_rst14", 1, 0, 4'd0, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(0, 0);
      chk("s6_idle10", 0, 0, 4'd0, 0, 0, 0, 0);
      chk("s6_idle14", 1, 0, 4'd0, 0, 0, 0, 0);
    end

    // NR=14 single run: 14 enables, done at t+16
    n_en = 0;
    step(1, 0);
    step(0, 0);
    chk("s7_init", 1, 1, 4'd0, 0, 0, 0, 1);
    for (int j = 0; j < 14; j++) begin
      step(0, 0);
      n_en += int'(rnd_en_b);
      chk("s7_run", 1, 0, 4'(j), 1, (j == 13), 0, 1);
    end
    step(0, 0);
    chk("s7_done", 1, 0, 4'd13, 0, 0, 1, 0);
    cmp("s7_en_count", 32'(n_en), 32'd14);
    step(0, 0);
    chk("s7_idle", 1, 0, 4'd0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
